// File: rtl/bias_update_unit.sv
// Training stage for the bias weight table: queues {index, weight} per prediction,
// applies the saturating update on resolve, and drives the table write port.
module bias_update_unit #(
  parameter int DEPTH    = 4,
  parameter int INDEX_W  = 10,
  parameter int WEIGHT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [INDEX_W-1:0]       pred_index,
  input  logic [WEIGHT_W-1:0]      pred_weight,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic                     flush,
  output logic                     upd_en,
  output logic [INDEX_W-1:0]       upd_index,
  output logic [WEIGHT_W-1:0]      upd_weight,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WEIGHT_W:0]   W_ONE    = {{WEIGHT_W{1'b0}}, 1'b1};
  localparam logic [WEIGHT_W:0]   W_MAX    = {1'b0, {WEIGHT_W{1'b1}}};

  logic [INDEX_W-1:0]  r_idx [DEPTH];
  logic [WEIGHT_W-1:0] r_wgt [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic                r_upd_en;
  logic [INDEX_W-1:0]  r_upd_index;
  logic [WEIGHT_W-1:0] r_upd_weight;
  logic                r_overflow;
  logic                r_underflow;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [INDEX_W-1:0]  w_head_idx;
  logic [WEIGHT_W-1:0] w_head_wgt;
  logic [WEIGHT_W:0]   w_sum;
  logic [WEIGHT_W-1:0] w_new_wgt;
  logic                w_changed;
  logic [WEIGHT_W-1:0] w_push_wgt;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_push     = pred_valid && !w_full && !flush;
  assign w_pop      = res_valid && !w_empty && !flush;
  assign w_head_idx = r_idx[r_head];
  assign w_head_wgt = r_wgt[r_head];

  // Saturating update computed one bit wider so wrap-around is visible in the MSB.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sum     = '0;
    w_new_wgt = w_head_wgt;
    if (res_taken) begin
      w_sum     = {1'b0, w_head_wgt} + W_ONE;
      w_new_wgt = (w_sum > W_MAX) ? W_MAX[WEIGHT_W-1:0] : w_sum[WEIGHT_W-1:0];
    end else begin
      w_sum     = {1'b0, w_head_wgt} - W_ONE;
      w_new_wgt = w_sum[WEIGHT_W] ? '0 : w_sum[WEIGHT_W-1:0];
    end
  end

  assign w_changed = (w_new_wgt != w_head_wgt);

  // A pushed entry must see the freshest weight for its slot, newest source first.
  always_comb begin
    w_push_wgt = pred_weight;
    if (w_pop && (w_head_idx == pred_index)) begin
      w_push_wgt = w_new_wgt;
    end else if (r_upd_en && (r_upd_index == pred_index)) begin
      w_push_wgt = r_upd_weight;
    end
  end

  // NOTE: queue storage carries no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_idx[i] == w_head_idx) begin
          r_wgt[i] <= w_new_wgt;
        end
      end
    end
    if (w_push) begin
      r_idx[r_tail] <= pred_index;
      r_wgt[r_tail] <= w_push_wgt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_upd_en     <= 1'b0;
      r_upd_index  <= '0;
      r_upd_weight <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_upd_en <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_upd_en <= w_pop && w_changed;
      if (w_pop) begin
        r_upd_index  <= w_head_idx;
        r_upd_weight <= w_new_wgt;
      end
      if (pred_valid && w_full) r_overflow  <= 1'b1;
      if (res_valid && w_empty) r_underflow <= 1'b1;
    end
  end

  assign pred_ready = !w_full;
  assign upd_en     = r_upd_en;
  assign upd_index  = r_upd_index;
  assign upd_weight = r_upd_weight;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_bias_update_unit.sv
// Directed bench for bias_update_unit: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_bias_update_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [9:0] pred_index;
  logic [1:0] pred_weight;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       flush;
  logic       upd_en;
  logic [9:0] upd_index;
  logic [1:0] upd_weight;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_errors = 0;

  bias_update_unit #(.DEPTH(4), .INDEX_W(10), .WEIGHT_W(2)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_index(pred_index), .pred_weight(pred_weight),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_en(upd_en), .upd_index(upd_index), .upd_weight(upd_weight),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pred_valid = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push(input logic [9:0] idx, input logic [1:0] w);
    pred_valid  = 1'b1;
    pred_index  = idx;
    pred_weight = w;
  endtask

  task automatic resolve(input logic taken);
    res_valid = 1'b1;
    res_taken = taken;
  endtask

  initial begin
    rst = 1'b1;
    pred_index = '0;
    pred_weight = '0;
    idle();
    tick(); tick();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_upd_en", upd_en, 0);
    check("rst_upd_index", upd_index, 0);
    check("rst_upd_weight", upd_weight, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ready", pred_ready, 1);

    // Basic taken update of (5,1)
    push(10'd5, 2'd1); tick(); idle();
    check("t1_count_push", count, 1);
    resolve(1'b1); tick(); idle();
    check("t1_upd_en", upd_en, 1);
    check("t1_upd_index", upd_index, 5);
    check("t1_upd_weight", upd_weight, 2);
    check("t1_count_pop", count, 0);
    tick();
    check("t1_upd_pulse", upd_en, 0);

    // Saturated pops produce no write
    push(10'd7, 2'd3); tick(); idle();
    resolve(1'b1); tick(); idle();
    check("t2_sat_hi", upd_en, 0);
    push(10'd7, 2'd0); tick(); idle();
    resolve(1'b0); tick(); idle();
    check("t2_sat_lo", upd_en, 0);
    check("t2_count", count, 0);

    // Aliased entries: second one patched by first pop
    push(10'd9, 2'd1); tick();
    push(10'd9, 2'd1); tick(); idle();
    check("t3_count", count, 2);
    resolve(1'b1); tick();
    check("t3_w1_en", upd_en, 1);
    check("t3_w1_idx", upd_index, 9);
    check("t3_w1_wgt", upd_weight, 2);
    tick(); idle();
    check("t3_w2_en", upd_en, 1);
    check("t3_w2_wgt", upd_weight, 3);
    tick();

    // Push aliasing a same-cycle pop takes the popped result
    push(10'd9, 2'd1); tick();
    push(10'd9, 2'd1); resolve(1'b1); tick(); idle();
    check("t4_pop_wgt", upd_weight, 2);
    check("t4_count", count, 1);
    resolve(1'b1); tick(); idle();
    check("t4_byp_en", upd_en, 1);
    check("t4_byp_wgt", upd_weight, 3);
    tick();

    // Push aliasing a pending write takes upd_weight
    push(10'd3, 2'd1); tick(); idle();
    resolve(1'b1); tick(); idle();
    check("t4b_upd_wgt", upd_weight, 2);
    push(10'd3, 2'd1); tick(); idle();
    resolve(1'b1); tick(); idle();
    check("t4b_byp_en", upd_en, 1);
    check("t4b_byp_wgt", upd_weight, 3);
    tick();

    // Fill, overflow, drain in order, underflow
    push(10'd1, 2'd0); tick();
    push(10'd2, 2'd0); tick();
    push(10'd3, 2'd0); tick();
    check("t5_ready_3", pred_ready, 1);
    push(10'd4, 2'd0); tick();
    check("t5_full_count", count, 4);
    check("t5_ready_full", pred_ready, 0);
    check("t5_no_ovf_yet", overflow, 0);
    push(10'd5, 2'd0); tick(); idle();
    check("t5_overflow", overflow, 1);
    check("t5_count_ovf", count, 4);
    check("t5_ready_ovf", pred_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      resolve(1'b1); tick();
      check("t5_drain_en", upd_en, 1);
      check("t5_drain_idx", upd_index, i);
      check("t5_drain_wgt", upd_weight, 1);
    end
    check("t5_empty", count, 0);
    check("t5_no_udf_yet", underflow, 0);
    resolve(1'b1); tick(); idle();
    check("t5_underflow", underflow, 1);
    check("t5_udf_no_upd", upd_en, 0);
    check("t5_ready_empty", pred_ready, 1);

    // Flush with simultaneous push and pop
    push(10'd6, 2'd1); tick();
    push(10'd6, 2'd1); tick();
    push(10'd8, 2'd1); tick();
    check("t6_count3", count, 3);
    push(10'd10, 2'd1); resolve(1'b1); flush = 1'b1; tick(); idle();
    check("t6_flush_count", count, 0);
    check("t6_flush_upd", upd_en, 0);
    check("t6_keep_ovf", overflow, 1);
    check("t6_keep_udf", underflow, 1);
    push(10'd2, 2'd2); tick(); idle();
    check("t6_count1", count, 1);
    resolve(1'b0); tick(); idle();
    check("t6_upd_en", upd_en, 1);
    check("t6_upd_idx", upd_index, 2);
    check("t6_upd_wgt", upd_weight, 1);

    // Reset mid-operation cancels the pending write
    push(10'd11, 2'd1); tick(); idle();
    resolve(1'b1); rst = 1'b1; tick(); idle();
    rst = 1'b0;
    check("t7_rst_upd", upd_en, 0);
    check("t7_rst_count", count, 0);
    check("t7_rst_ovf", overflow, 0);
    check("t7_rst_udf", underflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
